spi_word_receiver: RTL and testbench

SPI target (slave) that deserialises the galvo-DAC SPI stream (sclk/mosi/cs) back into parallel words in the system clock domain. It is used as the loopback/capture endpoint for the x/y SPI links, either on a second board or in-fabric for self-test. It oversamples the asynchronous SPI pins, frames words on chip-select, flags framing errors, and presents each completed word on a valid/ready interface.

---
 rtl/spi_pkg.sv | 13 +
 rtl/sync_ff.sv | 25 ++
 rtl/spi_word_receiver.sv | 203 ++++++++++++++++++++
 tb/tb_spi_word_receiver.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI word receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        COMPLETE = 2'd2
    } rx_state_t;

    localparam int DEFAULT_DAC_WORD_LENGTH = 16;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with a selectable reset value.
module sync_ff #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    // Shift the asynchronous input through DEPTH flops; reset forces the idle level.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            stages <= {DEPTH{RESET_VAL}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_word_receiver.sv
// SPI target that deserialises sclk/mosi/cs into parallel words on a
// valid/ready interface in the clock_in domain.
// Optional build macro: SPI_RX_TIMEOUT_EN aborts a frame after TIMEOUT_CYCLES
// system clocks in RECEIVE without an sclk rising edge.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | cs high (or frame aborted); waiting for an armed cs fall
// RECEIVE  | cs low; shifting mosi in MSB first on each sclk rise
// COMPLETE | one cycle after cs rise; word offered, dropped or flagged
module spi_word_receiver
    import spi_pkg::*;
#(
    parameter int DATA_LENGTH    = DEFAULT_DAC_WORD_LENGTH,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   sclk_in,
    input  logic                   mosi_in,
    input  logic                   cs_in,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   framing_error_out,
    output logic                   overrun_out,
    output logic [15:0]            word_count_out
);

    localparam int CNT_W = $clog2(DATA_LENGTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_LENGTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_LENGTH + 1);

    if (DATA_LENGTH < 1 || DATA_LENGTH > 32) begin : g_bad_length
        $error("DATA_LENGTH must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic sclk_sync, mosi_sync, cs_sync;
    logic sclk_prev, cs_prev;
    logic [SYNC_STAGES-1:0] settle_q;
    logic cs_armed;
    logic sclk_rise, cs_rise, cs_fall, frame_start, settled;
    logic timeout_hit;

    rx_state_t state_q, state_d;
    logic clear_frame, shift_en, word_done, frame_bad;

    logic [DATA_LENGTH-1:0] shift_q;
    logic [CNT_W-1:0]       bit_cnt;

    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock_in(clock_in), .reset_in(reset_in), .d(sclk_in), .q(sclk_sync)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clock_in(clock_in), .reset_in(reset_in), .d(mosi_in), .q(mosi_sync)
    );
    sync_ff #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock_in(clock_in), .reset_in(reset_in), .d(cs_in), .q(cs_sync)
    );

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign cs_rise   = cs_sync & ~cs_prev;
    assign cs_fall   = cs_prev & ~cs_sync;
    assign settled   = settle_q[SYNC_STAGES-1];
    // A cs fall only starts a frame once cs has been seen high from real pin
    // samples, so a cs held low across reset release is not a frame start.
    assign frame_start = cs_fall & cs_armed;

    // Edge-detect history, synchroniser settle tracking and frame arming.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            settle_q  <= '0;
            cs_armed  <= 1'b0;
        end else begin
            sclk_prev <= sclk_sync;
            cs_prev   <= cs_sync;
            settle_q  <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            if (timeout_hit) begin
                cs_armed <= 1'b0;
            end else if (settled && cs_sync) begin
                cs_armed <= 1'b1;
            end
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Down-counter reloaded outside RECEIVE and on every sclk rise.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            to_cnt <= TO_LOAD;
        end else if (state_q != RECEIVE || sclk_rise) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end

    assign timeout_hit = (state_q == RECEIVE) && !sclk_rise && !cs_rise && (to_cnt == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and frame control decode.
    always_comb begin
        state_d     = state_q;
        clear_frame = 1'b0;
        shift_en    = 1'b0;
        word_done   = 1'b0;
        frame_bad   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = RECEIVE;
                    clear_frame = 1'b1;
                end
            end
            RECEIVE: begin
                shift_en = sclk_rise & ~cs_sync;
                if (cs_rise) begin
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            COMPLETE: begin
                word_done = (bit_cnt == CNT_FULL);
                frame_bad = (bit_cnt != CNT_FULL) && (bit_cnt != '0);
                if (frame_start) begin
                    state_d     = RECEIVE;
                    clear_frame = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (clear_frame) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= DATA_LENGTH'({shift_q, mosi_sync});
            if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Holding register with valid/ready handshake, word counter and status pulses.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            data_out          <= '0;
            valid_out         <= 1'b0;
            word_count_out    <= '0;
            framing_error_out <= 1'b0;
            overrun_out       <= 1'b0;
        end else begin
            framing_error_out <= frame_bad | timeout_hit;
            overrun_out       <= 1'b0;
            if (word_done) begin
                if (!valid_out || ready_in) begin
                    data_out       <= shift_q;
                    valid_out      <= 1'b1;
                    word_count_out <= word_count_out + 16'd1;
                end else begin
                    overrun_out <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_word_receiver.sv
module tb_spi_word_receiver;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        sclk_in, mosi_in, cs_in, ready_in;
    logic [15:0] data_out;
    logic        valid_out, framing_error_out, overrun_out;
    logic [15:0] word_count_out;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, vrise_cnt = 0;
    logic valid_prev = 1'b0;
    logic [15:0] exp_q[$];
`ifdef SPI_RX_TIMEOUT_EN
    int exp_stall_fe = 1;
`else
    int exp_stall_fe = 0;
`endif

    spi_word_receiver #(
        .DATA_LENGTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clock_in(clock_in), .reset_in(reset_in), .sclk_in(sclk_in),
        .mosi_in(mosi_in), .cs_in(cs_in), .data_out(data_out),
        .valid_out(valid_out), .ready_in(ready_in),
        .framing_error_out(framing_error_out), .overrun_out(overrun_out),
        .word_count_out(word_count_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] value, input int n);
        for (int i = 0; i < n; i++) begin
            mosi_in = value[n-1-i];
            repeat (4) tick();
            sclk_in = 1'b1;
            repeat (4) tick();
            sclk_in = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] value, input int n, input int gap);
        cs_in = 1'b0;
        repeat (4) tick();
        send_bits(value, n);
        repeat (4) tick();
        cs_in = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        repeat (3) tick();
        reset_in = 1'b0;
        repeat (4) tick();
        fe_cnt = 0; ov_cnt = 0; xfer_cnt = 0; vrise_cnt = 0;
    endtask

    // Scoreboard monitor: pop expected words on each handshake, count pulses.
    always @(negedge clock_in) begin
        if (!reset_in) begin
            if (framing_error_out) fe_cnt++;
            if (overrun_out) ov_cnt++;
            if (valid_out && !valid_prev) vrise_cnt++;
            if (valid_out && ready_in) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {16'h0, data_out}, 32'hDEAD_BEEF);
                end else begin
                    check("word_data", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
                end
            end
            valid_prev = valid_out;
        end else begin
            valid_prev = 1'b0;
        end
    end

    initial begin
        reset_in = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0; cs_in = 1'b1; ready_in = 1'b1;
        repeat (3) tick();
        check("rst_data", {16'h0, data_out}, 32'h0);
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_wc", {16'h0, word_count_out}, 32'h0);
        check("rst_fe", {31'h0, framing_error_out}, 32'h0);
        check("rst_ov", {31'h0, overrun_out}, 32'h0);
        do_reset();

        // 1: single word with latency check
        cs_in = 1'b0;
        repeat (4) tick();
        send_bits(32'hA5C3, 16);
        repeat (4) tick();
        exp_q.push_back(16'hA5C3);
        cs_in = 1'b1;
        repeat (3) tick();
        check("t1_valid_early", {31'h0, valid_out}, 32'h0);
        tick();
        check("t1_valid_on_time", {31'h0, valid_out}, 32'h1);
        check("t1_data", {16'h0, data_out}, 32'hA5C3);
        check("t1_wc", {16'h0, word_count_out}, 32'h1);
        repeat (5) tick();
        check("t1_xfer", xfer_cnt, 1);
        check("t1_vrise", vrise_cnt, 1);
        check("t1_fe", fe_cnt, 0);
        check("t1_ov", ov_cnt, 0);
        check("t1_valid_low", {31'h0, valid_out}, 32'h0);

        // 2: short and long frames
        do_reset();
        send_frame(32'h0ABC, 12, 10);
        send_frame(32'h1_2345, 17, 10);
        check("t2_fe", fe_cnt, 2);
        check("t2_vrise", vrise_cnt, 0);
        check("t2_wc", {16'h0, word_count_out}, 32'h0);

        // 3: overrun with ready low
        do_reset();
        ready_in = 1'b0;
        exp_q.push_back(16'h1234);
        send_frame(32'h1234, 16, 10);
        send_frame(32'h5678, 16, 10);
        check("t3_ov", ov_cnt, 1);
        check("t3_data", {16'h0, data_out}, 32'h1234);
        check("t3_valid", {31'h0, valid_out}, 32'h1);
        check("t3_wc", {16'h0, word_count_out}, 32'h1);
        ready_in = 1'b1;
        repeat (3) tick();
        check("t3_xfer", xfer_cnt, 1);
        check("t3_valid_low", {31'h0, valid_out}, 32'h0);
        check("t3_q_empty", exp_q.size(), 0);

        // 4: back-to-back frames with 2-cycle cs-high gaps
        do_reset();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        send_frame(32'h0001, 16, 2);
        send_frame(32'h0002, 16, 2);
        repeat (10) tick();
        check("t4_xfer", xfer_cnt, 2);
        check("t4_ov", ov_cnt, 0);
        check("t4_wc", {16'h0, word_count_out}, 32'h2);
        check("t4_q_empty", exp_q.size(), 0);

        // 5: asynchronous reset mid-frame with cs held low
        do_reset();
        cs_in = 1'b0;
        repeat (4) tick();
        send_bits(32'hFF, 8);
        repeat (2) tick();
        #3 reset_in = 1'b1;
        repeat (3) tick();
        reset_in = 1'b0;
        repeat (4) tick();
        send_bits(32'hFF, 8);
        repeat (4) tick();
        cs_in = 1'b1;
        repeat (10) tick();
        check("t5_vrise", vrise_cnt, 0);
        check("t5_fe", fe_cnt, 0);
        check("t5_valid", {31'h0, valid_out}, 32'h0);
        check("t5_wc", {16'h0, word_count_out}, 32'h0);
        exp_q.push_back(16'h0F0F);
        send_frame(32'h0F0F, 16, 10);
        check("t5_xfer", xfer_cnt, 1);
        check("t5_wc_after", {16'h0, word_count_out}, 32'h1);

        // 6: stalled sclk with cs low
        do_reset();
        cs_in = 1'b0;
        repeat (4) tick();
        send_bits(32'h16, 5);
        repeat (100) tick();
        check("t6_stall_fe", fe_cnt, exp_stall_fe);
        cs_in = 1'b1;
        repeat (10) tick();
        check("t6_fe_total", fe_cnt, 1);
        check("t6_vrise", vrise_cnt, 0);
        exp_q.push_back(16'hBEEF);
        send_frame(32'hBEEF, 16, 10);
        check("t6_xfer", xfer_cnt, 1);
        check("t6_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
